bt_uart_word_rx: RTL and testbench
==================================

Name: bt_uart_word_rx

Overview:
- Receive path upstream of the Bluetooth connection block.
- Synchronises the serial line from the Bluetooth module (fpga_rxd) and deserialises 8N1 UART frames.
- Pairs consecutive bytes into 16-bit words, matching the 16-bit endpoint wire width.
- Presents each word on a valid/ack handshake, with sticky framing and overrun error flags for status readback.

Parameters:
- CLKS_PER_BIT, 10: clock cycles per UART bit. Legal values are >= 4; the divide need not be exact, it is integer-rounded.
- SYNC_STAGES, 2: number of synchroniser flops on rxd. Legal values are >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rxd  in  1  serial data from the Bluetooth module; idles high.
- bt_state  in  1  link-up indicator from the Bluetooth module. While low, the receiver is held idle.
- clear_err  in  1  one-cycle pulse; clears frame_err and overrun.
- word_ack  in  1  consumer accepts word_out.
- byte_out  out  8  last byte received.
- byte_valid  out  1  one-cycle pulse per good byte.
- word_out  out  16  assembled word; the first byte received is [15:8], the second is [7:0].
- word_valid  out  1  high from word completion until acked.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a word was dropped because word_valid was still high.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Synchroniser flops reset to 1.
  - FSM resets to IDLE; bit counter, tick counter and half-word flag reset to 0.
- Sampling: rxd passes through SYNC_STAGES flops. All decisions use the synchronised value rxs.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: when rxs==0 and bt_state==1, go to START and clear the tick counter.
  - START: at tick CLKS_PER_BIT/2-1, sample rxs.
    - If rxs==0, go to DATA and clear the tick counter and bit index.
    - Otherwise it was a glitch: return to IDLE with no output.
  - DATA: each time the tick counter reaches CLKS_PER_BIT-1, shift rxs into the byte LSB-first and restart the tick counter. After bit index 7, go to STOP.
  - STOP: at tick CLKS_PER_BIT-1 (mid stop bit), sample rxs.
    - If rxs==1, the byte is good.
    - If rxs==0, set frame_err, discard the byte, and clear the half-word flag.
    - In both cases return to IDLE immediately. A back-to-back start bit is caught from the next cycle.
- Byte output: byte_out updates and byte_valid pulses high for exactly 1 cycle, in the cycle after the good stop sample.
- Word pairing:
  - On a good byte with half=0: latch it as the high byte and set half=1.
  - On a good byte with half=1: form the word, clear half, and in the same cycle as byte_valid:
    - If word_valid==0, or word_ack is high this cycle: load word_out and set word_valid=1.
    - Otherwise: keep the old word, set overrun, and drop the new word.
- Handshake:
  - word_valid falls in the cycle after word_ack is sampled high.
  - word_ack while word_valid==0 is ignored.
  - word_out is stable while word_valid==1.
- Errors: frame_err and overrun clear only on clear_err. If a set event and clear_err occur in the same cycle, the set wins.
- Link drop: bt_state low at any point forces IDLE and clears half and the counters on the next edge. A partial byte or word is lost. word_valid, word_out and the sticky flags are retained.
- Mid-frame reset: asynchronous; all state returns to reset values immediately.
- busy is a combinational decode of state != IDLE.

Decomposition:
- Package bt_uart_pkg holds:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3);
  - DATA_BITS=8, WORD_BITS=16;
  - a function computing the tick-counter width from CLKS_PER_BIT.
- One sub-module, bt_rx_sync: a parameterised SYNC_STAGES flop chain with reset-to-1, shared later with other asynchronous inputs such as bt_state.

Test Plan:
All scenarios use CLKS_PER_BIT=10 and bt_state=1 unless stated.
1. Send frames 0xA5 then 0x3C at exact bit timing.
   -> byte_valid pulses twice with byte_out = A5, then 3C.
   -> word_valid rises together with the second pulse, word_out = 16'hA53C.
   -> word_ack clears word_valid on the following cycle.
2. Two complete words 0x1234 and 0x5678 with no ack.
   -> word_out stays 16'h1234 and overrun=1.
   -> clear_err pulse -> overrun=0.
3. Frame 0x55 with the stop bit driven low.
   -> frame_err=1, no byte_valid.
   -> Then send 0x11 and 0x22: word_out = 16'h1122, confirming the half-word was cleared.
4. A 3-cycle low glitch on idle rxd -> returns to IDLE, no byte_valid, frame_err stays 0.
5. Send byte 0xAB, drop bt_state for 5 cycles, restore it, then send 0xCD and 0xEF.
   -> word_out = 16'hCDEF; 0xAB is discarded.
6. Assert resetn=0 mid DATA of a frame.
   -> All outputs are 0 immediately.
   -> After release, the frame pair 0x01, 0x02 gives word_out = 16'h0102.

Source files
------------

// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the Bluetooth UART receive path.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned WORD_BITS = 16;

  // Width able to count 0..clks-1; never narrower than one bit.
  function automatic int unsigned tick_width(input int unsigned clks);
    if (clks <= 32'd2) begin
      return 32'd1;
    end
    return unsigned'($clog2(clks));
  endfunction

endpackage

// File: rtl/bt_rx_sync.sv
// Reset-to-1 flop chain bringing an asynchronous idle-high input into the clock domain.
module bt_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bt_uart_word_rx.sv
// 8N1 UART receiver that pairs bytes into 16-bit words behind a valid/ack handshake,
// with sticky framing and overrun flags.
module bt_uart_word_rx
  import bt_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 rxd,
  input  logic                 bt_state,
  input  logic                 clear_err,
  input  logic                 word_ack,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 byte_valid,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = tick_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic rxs;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 half_q, half_d;
  logic [DATA_BITS-1:0] hi_q, hi_d;
  logic [DATA_BITS-1:0] byte_out_q, byte_out_d;
  logic                 byte_valid_q, byte_valid_d;
  logic [WORD_BITS-1:0] word_out_q, word_out_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  bt_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rxd_sync (
    .clk  (clock),
    .rst_n(resetn),
    .d    (rxd),
    .q    (rxs)
  );

  // Next-state, deserialiser and word-pairing logic
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    half_d       = half_q;
    hi_d         = hi_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q & ~word_ack;
    frame_err_d  = frame_err_q & ~clear_err;
    overrun_d    = overrun_q & ~clear_err;

    if (!bt_state) begin
      // Link down: abandon any partial byte or word, keep delivered state
      state_d = ST_IDLE;
      tick_d  = '0;
      bit_d   = '0;
      half_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            if (rxs) begin
              byte_out_d   = shift_q;
              byte_valid_d = 1'b1;
              if (!half_q) begin
                hi_d   = shift_q;
                half_d = 1'b1;
              end else begin
                half_d = 1'b0;
                if (!word_valid_q || word_ack) begin
                  word_out_d   = {hi_q, shift_q};
                  word_valid_d = 1'b1;
                end else begin
                  overrun_d = 1'b1;
                end
              end
            end else begin
              frame_err_d = 1'b1;
              half_d      = 1'b0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      half_q       <= 1'b0;
      hi_q         <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      half_q       <= half_d;
      hi_q         <= hi_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bt_uart_word_rx.sv
// Scoreboard bench for bt_uart_word_rx: directed frames with queued expected bytes and words.
module tb_bt_uart_word_rx;

  localparam int unsigned CPB = 10;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        rxd = 1'b1;
  logic        bt_state = 1'b1;
  logic        clear_err = 1'b0;
  logic        word_ack = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_words[$];

  bt_uart_word_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rxd       (rxd),
    .bt_state  (bt_state),
    .clear_err (clear_err),
    .word_ack  (word_ack),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one 8N1 frame; stop_ok=0 drives a low stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clock);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_ok;
    idle(CPB);
    rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    word_ack = 1'b1;
    @(negedge clock);
    word_ack = 1'b0;
  endtask

  // Monitor: compares every byte pulse and every new word against the queues
  initial begin
    logic wv_prev;
    logic [7:0]  eb;
    logic [15:0] ew;
    wv_prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetn) begin
        wv_prev = 1'b0;
      end else begin
        if (byte_valid) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_unexpected got %h expected none", byte_out);
          end else begin
            eb = exp_bytes.pop_front();
            chk("byte_out", {8'h00, byte_out}, {8'h00, eb});
          end
        end
        if (word_valid && !wv_prev) begin
          chk("word_with_byte_valid", {15'd0, byte_valid}, 16'd1);
          if (exp_words.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected got %h expected none", word_out);
          end else begin
            ew = exp_words.pop_front();
            chk("word_out", word_out, ew);
          end
        end
        wv_prev = word_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_byte_out", {8'h00, byte_out}, 16'h0000);
    chk("rst_flags", {10'd0, byte_valid, word_valid, frame_err, overrun, busy, 1'b0}, 16'h0000);
    chk("rst_word_out", word_out, 16'h0000);
    resetn = 1'b1;
    idle(5);

    // 1: basic pair and handshake
    exp_bytes.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    exp_bytes.push_back(8'h3C);
    exp_words.push_back(16'hA53C);
    send_byte(8'h3C, 1'b1);
    idle(3);
    chk("t1_word_valid", {15'd0, word_valid}, 16'd1);
    pulse_ack();
    chk("t1_ack_clears", {15'd0, word_valid}, 16'd0);
    idle(5);

    // 2: overrun with no ack
    exp_bytes.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    exp_bytes.push_back(8'h34);
    exp_words.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    exp_bytes.push_back(8'h56);
    send_byte(8'h56, 1'b1);
    exp_bytes.push_back(8'h78);
    send_byte(8'h78, 1'b1);
    idle(3);
    chk("t2_word_kept", word_out, 16'h1234);
    chk("t2_overrun", {15'd0, overrun}, 16'd1);
    @(negedge clock);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    chk("t2_overrun_cleared", {15'd0, overrun}, 16'd0);
    chk("t2_still_valid", {15'd0, word_valid}, 16'd1);
    pulse_ack();
    idle(5);

    // 3: framing error clears the pending high byte
    exp_bytes.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(20);
    chk("t3_frame_err", {15'd0, frame_err}, 16'd1);
    exp_bytes.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    exp_bytes.push_back(8'h22);
    exp_words.push_back(16'h1122);
    send_byte(8'h22, 1'b1);
    idle(3);
    chk("t3_word", word_out, 16'h1122);
    pulse_ack();
    @(negedge clock);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    chk("t3_frame_err_cleared", {15'd0, frame_err}, 16'd0);

    // 4: short glitch on idle line
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(20);
    chk("t4_busy", {15'd0, busy}, 16'd0);
    chk("t4_frame_err", {15'd0, frame_err}, 16'd0);

    // 5: link drop discards pending high byte
    exp_bytes.push_back(8'hAB);
    send_byte(8'hAB, 1'b1);
    idle(2);
    bt_state = 1'b0;
    idle(5);
    bt_state = 1'b1;
    idle(5);
    exp_bytes.push_back(8'hCD);
    send_byte(8'hCD, 1'b1);
    exp_bytes.push_back(8'hEF);
    exp_words.push_back(16'hCDEF);
    send_byte(8'hEF, 1'b1);
    idle(3);
    chk("t5_word", word_out, 16'hCDEF);
    pulse_ack();
    idle(5);

    // 6: asynchronous reset in the middle of a data bit
    @(negedge clock);
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(CPB + 3);
    chk("t6_busy_before", {15'd0, busy}, 16'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_word_out", word_out, 16'h0000);
    chk("t6_rst_byte_out", {8'h00, byte_out}, 16'h0000);
    chk("t6_rst_flags", {11'd0, byte_valid, word_valid, frame_err, overrun, busy}, 16'h0000);
    rxd = 1'b1;
    idle(4);
    resetn = 1'b1;
    idle(20);
    exp_bytes.push_back(8'h01);
    send_byte(8'h01, 1'b1);
    exp_bytes.push_back(8'h02);
    exp_words.push_back(16'h0102);
    send_byte(8'h02, 1'b1);
    idle(3);
    chk("t6_word", word_out, 16'h0102);
    chk("t6_word_valid", {15'd0, word_valid}, 16'd1);

    idle(5);
    chk("bytes_drained", 16'(exp_bytes.size()), 16'd0);
    chk("words_drained", 16'(exp_words.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
